// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - 8N1 UART receiver packing 16-byte groups into 128-bit SDRAM writes
module uart_rx_loader #(
  parameter int          CLKS_PER_BIT    = 434,
  parameter logic [17:0] WORDS_PER_FRAME = 18'h9600
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RX,
  input  logic         start,
  input  logic [24:0]  base_addr,
  input  logic         ram_busy,
  output logic         wr_req,
  output logic [24:0]  wr_address,
  output logic [127:0] wr_data,
  output logic         done,
  output logic         frame_err,
  output logic         overflow,
  output logic         busy_led
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} ld_state_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          bad_stop_q, bad_stop_d;

  ld_state_t     ld_state_q, ld_state_d;
  logic          start_q;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [17:0]   word_cnt_q, word_cnt_d;
  logic [127:0]  asm_q, asm_d;
  logic [127:0]  hold_q, hold_d;
  logic          pending_q, pending_d;
  logic [24:0]   addr_q, addr_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 16'd1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    bad_stop_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = 16'd0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          byte_valid_d = rx_sync_q;
          bad_stop_d   = !rx_sync_q;
          rx_state_d   = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Request is gated combinationally so it fires on the first ram_busy=0 cycle.
  assign wr_req = (ld_state_q == WRITE) && pending_q && !ram_busy;

  always_comb begin
    ld_state_d  = ld_state_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    asm_d       = asm_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    frame_err_d = frame_err_q || bad_stop_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    case (ld_state_q)
      IDLE: begin
        if (start && !start_q) begin
          addr_d      = base_addr;
          byte_idx_d  = 4'd0;
          word_cnt_d  = 18'd0;
          frame_err_d = 1'b0;
          overflow_d  = 1'b0;
          pending_d   = 1'b0;
          busy_d      = 1'b1;
          ld_state_d  = COLLECT;
        end
      end
      COLLECT, WRITE: begin
        if (wr_req) begin
          pending_d = 1'b0;
          addr_d    = addr_q + 25'd4;
        end
        if (byte_valid_q) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
          byte_idx_d = byte_idx_q + 4'd1;
          if (byte_idx_q == 4'd15) begin
            // A word still waiting for the RAM cannot be replaced; the new one is lost.
            if (pending_q && !wr_req) begin
              overflow_d = 1'b1;
            end else begin
              hold_d     = {rx_shift_q, asm_q[119:0]};
              pending_d  = 1'b1;
              word_cnt_d = word_cnt_q + 18'd1;
            end
          end
        end
        if (wr_req && word_cnt_q == WORDS_PER_FRAME) begin
          pending_d  = 1'b0;
          ld_state_d = DONE;
        end else if (pending_d) begin
          ld_state_d = WRITE;
        end else begin
          ld_state_d = COLLECT;
        end
      end
      DONE: begin
        busy_d     = 1'b0;
        ld_state_d = IDLE;
      end
      default: ld_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_shift_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      bad_stop_q   <= 1'b0;
      ld_state_q   <= IDLE;
      start_q      <= 1'b0;
      byte_idx_q   <= 4'd0;
      word_cnt_q   <= 18'd0;
      asm_q        <= 128'd0;
      hold_q       <= 128'd0;
      pending_q    <= 1'b0;
      addr_q       <= 25'd0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_meta_q    <= RX;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      bad_stop_q   <= bad_stop_d;
      ld_state_q   <= ld_state_d;
      start_q      <= start;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      asm_q        <= asm_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign wr_address = addr_q;
  assign wr_data    = hold_q;
  assign done       = (ld_state_q == DONE);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign busy_led   = !busy_q;

endmodule
